// File: rtl/snake_body_if.sv
// Snake body controller bundle: direction/target/query inputs and status outputs.
// The game side drives through "master"; the body controller sits on "slave".
interface snake_body_if;
  logic [1:0] NAV_STATE;
  logic       GAME_EN;
  logic [7:0] TARGET_X;
  logic [6:0] TARGET_Y;
  logic [7:0] ADDRH;
  logic [6:0] ADDRV;
  logic       SNAKE_PIX;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic [5:0] LENGTH;
  logic       MOVE_TICK;
  logic       TARGET_HIT;
  logic       SELF_HIT;

  modport master (
    output NAV_STATE, GAME_EN, TARGET_X, TARGET_Y, ADDRH, ADDRV,
    input  SNAKE_PIX, HEAD_X, HEAD_Y, LENGTH, MOVE_TICK, TARGET_HIT, SELF_HIT
  );

  modport slave (
    input  NAV_STATE, GAME_EN, TARGET_X, TARGET_Y, ADDRH, ADDRV,
    output SNAKE_PIX, HEAD_X, HEAD_Y, LENGTH, MOVE_TICK, TARGET_HIT, SELF_HIT
  );
endinterface

// File: rtl/snake_body_controller.sv
// Snake body controller: steps the head once per game tick, shifts the body,
// grows on target capture, detects self-collision and answers pixel queries.
module snake_body_controller #(
  parameter int TICK_DIV = 5000000,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60
) (
  input  logic         CLK,
  input  logic         RESET,
  snake_body_if.slave  io_bus
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CNT_W-1:0]            r_tick_cnt;
  logic [MAX_LEN-1:0][7:0]     r_seg_x;
  logic [MAX_LEN-1:0][6:0]     r_seg_y;
  logic [MAX_LEN-1:0][7:0]     w_init_x;
  logic [MAX_LEN-1:0][6:0]     w_init_y;
  logic [5:0]                  r_length;
  logic                        r_move_tick;
  logic                        r_target_hit;
  logic                        r_snake_pix;

  logic [7:0]                  w_new_x;
  logic [6:0]                  w_new_y;
  logic [MAX_LEN-1:0]          w_body_hit;
  logic [MAX_LEN-1:0]          w_pix_hit;
  logic                        w_self_hit;
  logic                        w_tgt_hit;
  logic                        w_move_edge;
  logic                        w_reload;

  // Restart body: a vertical column hanging below the head, unused slots zero.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
      assign w_init_x[gi] = (gi < INIT_LEN) ? 8'(INIT_X)      : 8'd0;
      assign w_init_y[gi] = (gi < INIT_LEN) ? 7'(INIT_Y + gi) : 7'd0;
    end
  endgenerate

  // A move happens only on the terminal count while running and still enabled;
  // dropping GAME_EN always takes priority and reloads the start position.
  assign w_move_edge = (r_state == ST_RUN) && io_bus.GAME_EN && (r_tick_cnt == CNT_MAX);
  assign w_reload    = (r_state != ST_IDLE) && !io_bus.GAME_EN;

  // Candidate head cell with toroidal wrap on every border.
  always_comb begin
    w_new_x = r_seg_x[0];
    w_new_y = r_seg_y[0];
    case (io_bus.NAV_STATE)
      2'd0:    w_new_y = (r_seg_y[0] == 7'd0)          ? 7'(Y_MAX) : r_seg_y[0] - 7'd1;
      2'd1:    w_new_x = (r_seg_x[0] == 8'd0)          ? 8'(X_MAX) : r_seg_x[0] - 8'd1;
      2'd2:    w_new_x = (r_seg_x[0] == 8'(X_MAX))     ? 8'd0      : r_seg_x[0] + 8'd1;
      default: w_new_y = (r_seg_y[0] == 7'(Y_MAX))     ? 7'd0      : r_seg_y[0] + 7'd1;
    endcase
  end

  // Per-segment comparators. Collision skips the head and the current tail,
  // since the tail cell is vacated by the same move.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      if (gi == 0) begin : g_head
        assign w_body_hit[gi] = 1'b0;
      end else begin : g_body
        assign w_body_hit[gi] = ((6'(gi) + 6'd1) < r_length) &&
                                (r_seg_x[gi] == w_new_x) && (r_seg_y[gi] == w_new_y);
      end
      assign w_pix_hit[gi] = (6'(gi) < r_length) &&
                             (r_seg_x[gi] == io_bus.ADDRH) && (r_seg_y[gi] == io_bus.ADDRV);
    end
  endgenerate

  assign w_self_hit = |w_body_hit;
  assign w_tgt_hit  = (w_new_x == io_bus.TARGET_X) && (w_new_y == io_bus.TARGET_Y);

  // Game state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (io_bus.GAME_EN) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!io_bus.GAME_EN)                w_state_next = ST_IDLE;
        else if (w_move_edge && w_self_hit) w_state_next = ST_DEAD;
      end
      ST_DEAD: if (!io_bus.GAME_EN) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Tick counter, body shift/growth, status pulses and registered pixel lookup.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tick_cnt   <= '0;
      r_seg_x      <= w_init_x;
      r_seg_y      <= w_init_y;
      r_length     <= 6'(INIT_LEN);
      r_move_tick  <= 1'b0;
      r_target_hit <= 1'b0;
      r_snake_pix  <= 1'b0;
    end else begin
      r_move_tick  <= 1'b0;
      r_target_hit <= 1'b0;
      r_snake_pix  <= |w_pix_hit;
      if (w_reload) begin
        r_tick_cnt <= '0;
        r_seg_x    <= w_init_x;
        r_seg_y    <= w_init_y;
        r_length   <= 6'(INIT_LEN);
      end else if (r_state == ST_RUN) begin
        if (w_move_edge) begin
          r_tick_cnt  <= '0;
          r_move_tick <= 1'b1;
          if (!w_self_hit) begin
            r_seg_x      <= {r_seg_x[MAX_LEN-2:0], w_new_x};
            r_seg_y      <= {r_seg_y[MAX_LEN-2:0], w_new_y};
            r_target_hit <= w_tgt_hit;
            if (w_tgt_hit && (r_length < 6'(MAX_LEN))) r_length <= r_length + 6'd1;
          end
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end
    end
  end

  assign io_bus.HEAD_X     = r_seg_x[0];
  assign io_bus.HEAD_Y     = r_seg_y[0];
  assign io_bus.LENGTH     = r_length;
  assign io_bus.MOVE_TICK  = r_move_tick;
  assign io_bus.TARGET_HIT = r_target_hit;
  assign io_bus.SELF_HIT   = (r_state == ST_DEAD);
  assign io_bus.SNAKE_PIX  = r_snake_pix;

endmodule

// File: tb/tb_snake_body_controller.sv
// Directed bench for snake_body_controller with a short game tick.
module tb_snake_body_controller;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  snake_body_if bus();

  snake_body_controller #(
    .TICK_DIV (4),
    .INIT_LEN (4)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .io_bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-20s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance until the next MOVE_TICK pulse, bounded so a dead design cannot hang.
  task automatic wait_move(input string tag);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!bus.MOVE_TICK && n < 10);
    check(tag, 32'(bus.MOVE_TICK), 32'd1);
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    RESET = 1'b1;
    bus.NAV_STATE = 2'd0;
    bus.GAME_EN   = 1'b0;
    bus.TARGET_X  = 8'd200;
    bus.TARGET_Y  = 7'd0;
    bus.ADDRH     = 8'd80;
    bus.ADDRV     = 7'd63;

    // Reset state
    tick(2);
    check("rst_head_x", 32'(bus.HEAD_X), 32'd80);
    check("rst_head_y", 32'(bus.HEAD_Y), 32'd60);
    check("rst_length", 32'(bus.LENGTH), 32'd4);
    check("rst_move_tick", 32'(bus.MOVE_TICK), 32'd0);
    check("rst_target_hit", 32'(bus.TARGET_HIT), 32'd0);
    check("rst_self_hit", 32'(bus.SELF_HIT), 32'd0);
    check("rst_snake_pix", 32'(bus.SNAKE_PIX), 32'd0);
    RESET = 1'b0;

    // Pixel queries in IDLE: tail of initial body, then one cell past it
    tick(1);
    check("idle_pix_tail", 32'(bus.SNAKE_PIX), 32'd1);
    bus.ADDRV = 7'd64;
    tick(1);
    check("idle_pix_off", 32'(bus.SNAKE_PIX), 32'd0);

    // First move lands 5 edges after GAME_EN rises
    bus.GAME_EN = 1'b1;
    tick(4);
    check("pre_move_tick", 32'(bus.MOVE_TICK), 32'd0);
    check("pre_move_y", 32'(bus.HEAD_Y), 32'd60);
    tick(1);
    check("first_move_tick", 32'(bus.MOVE_TICK), 32'd1);
    check("first_move_x", 32'(bus.HEAD_X), 32'd80);
    check("first_move_y", 32'(bus.HEAD_Y), 32'd59);
    check("first_move_len", 32'(bus.LENGTH), 32'd4);
    tick(1);
    check("move_tick_drop", 32'(bus.MOVE_TICK), 32'd0);

    // Walk up to row 0, then wrap to Y_MAX
    for (int i = 0; i < 59; i++) wait_move("up_move");
    check("up_top_y", 32'(bus.HEAD_Y), 32'd0);
    wait_move("up_wrap_move");
    check("up_wrap_x", 32'(bus.HEAD_X), 32'd80);
    check("up_wrap_y", 32'(bus.HEAD_Y), 32'd119);

    // Walk right to X_MAX, then wrap to 0
    bus.NAV_STATE = 2'd2;
    for (int i = 0; i < 79; i++) wait_move("right_move");
    check("right_edge_x", 32'(bus.HEAD_X), 32'd159);
    wait_move("right_wrap_move");
    check("right_wrap_x", 32'(bus.HEAD_X), 32'd0);
    check("right_wrap_y", 32'(bus.HEAD_Y), 32'd119);

    // Restart reloads the start body
    bus.GAME_EN = 1'b0;
    tick(1);
    check("restart1_x", 32'(bus.HEAD_X), 32'd80);
    check("restart1_y", 32'(bus.HEAD_Y), 32'd60);
    check("restart1_len", 32'(bus.LENGTH), 32'd4);

    // Growth: target on the next head cell
    bus.TARGET_X  = 8'd80;
    bus.TARGET_Y  = 7'd59;
    bus.NAV_STATE = 2'd0;
    bus.GAME_EN   = 1'b1;
    wait_move("grow1_move");
    check("grow1_y", 32'(bus.HEAD_Y), 32'd59);
    check("grow1_hit", 32'(bus.TARGET_HIT), 32'd1);
    check("grow1_len", 32'(bus.LENGTH), 32'd5);
    bus.ADDRH = 8'd80;
    bus.ADDRV = 7'd63;
    tick(1);
    check("grow1_old_tail_pix", 32'(bus.SNAKE_PIX), 32'd1);
    check("grow1_hit_drop", 32'(bus.TARGET_HIT), 32'd0);
    bus.ADDRV = 7'd64;
    tick(1);
    check("grow1_beyond_pix", 32'(bus.SNAKE_PIX), 32'd0);
    bus.TARGET_Y = 7'd58;
    wait_move("grow2_move");
    check("grow2_y", 32'(bus.HEAD_Y), 32'd58);
    check("grow2_hit", 32'(bus.TARGET_HIT), 32'd1);
    check("grow2_len", 32'(bus.LENGTH), 32'd6);
    bus.TARGET_X = 8'd200;
    bus.TARGET_Y = 7'd0;

    // Steer UP, LEFT, DOWN, RIGHT into own body; target parked on the
    // colliding cell so collision must win over capture
    wait_move("loop_up_move");
    check("loop_up_y", 32'(bus.HEAD_Y), 32'd57);
    bus.NAV_STATE = 2'd1;
    wait_move("loop_left_move");
    check("loop_left_x", 32'(bus.HEAD_X), 32'd79);
    bus.NAV_STATE = 2'd3;
    wait_move("loop_down_move");
    check("loop_down_y", 32'(bus.HEAD_Y), 32'd58);
    bus.NAV_STATE = 2'd2;
    bus.TARGET_X  = 8'd80;
    bus.TARGET_Y  = 7'd58;
    wait_move("collide_move");
    check("collide_self_hit", 32'(bus.SELF_HIT), 32'd1);
    check("collide_target_hit", 32'(bus.TARGET_HIT), 32'd0);
    check("collide_head_x", 32'(bus.HEAD_X), 32'd79);
    check("collide_head_y", 32'(bus.HEAD_Y), 32'd58);
    check("collide_len", 32'(bus.LENGTH), 32'd6);
    bus.TARGET_X = 8'd200;
    bus.TARGET_Y = 7'd0;
    bus.ADDRH    = 8'd80;
    bus.ADDRV    = 7'd60;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.MOVE_TICK) pulses++;
    end
    check("dead_no_moves", 32'(pulses), 32'd0);
    check("dead_self_hit", 32'(bus.SELF_HIT), 32'd1);
    check("dead_head_x", 32'(bus.HEAD_X), 32'd79);
    check("dead_tail_pix", 32'(bus.SNAKE_PIX), 32'd1);

    // Restart out of DEAD
    bus.GAME_EN = 1'b0;
    tick(1);
    check("restart2_self_hit", 32'(bus.SELF_HIT), 32'd0);
    check("restart2_x", 32'(bus.HEAD_X), 32'd80);
    check("restart2_y", 32'(bus.HEAD_Y), 32'd60);
    check("restart2_len", 32'(bus.LENGTH), 32'd4);

    // Length-4 loop: new head lands on the old tail cell, no collision
    bus.NAV_STATE = 2'd1;
    bus.GAME_EN   = 1'b1;
    wait_move("tail_left_move");
    check("tail_left_x", 32'(bus.HEAD_X), 32'd79);
    bus.NAV_STATE = 2'd3;
    wait_move("tail_down_move");
    check("tail_down_y", 32'(bus.HEAD_Y), 32'd61);
    bus.NAV_STATE = 2'd2;
    wait_move("tail_right_move");
    check("tail_right_x", 32'(bus.HEAD_X), 32'd80);
    check("tail_right_y", 32'(bus.HEAD_Y), 32'd61);
    check("tail_self_hit", 32'(bus.SELF_HIT), 32'd0);

    // Asynchronous reset with counter at 2, before the move edge
    tick(2);
    RESET = 1'b1;
    #1;
    check("async_rst_x", 32'(bus.HEAD_X), 32'd80);
    check("async_rst_y", 32'(bus.HEAD_Y), 32'd60);
    check("async_rst_len", 32'(bus.LENGTH), 32'd4);
    check("async_rst_pix", 32'(bus.SNAKE_PIX), 32'd0);
    check("async_rst_move_tick", 32'(bus.MOVE_TICK), 32'd0);
    tick(3);
    check("held_rst_y", 32'(bus.HEAD_Y), 32'd60);
    check("held_rst_move_tick", 32'(bus.MOVE_TICK), 32'd0);
    RESET = 1'b0;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
